// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter that frames byte streams from several readback sources
// into header-prefixed packets for the FTDI upstream write FIFO.
module ftdi_tx_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_prog_full,
  output logic              fifo_wr_en,
  output logic [7:0]        fifo_din,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [IW:0]   NREQ_W = (IW + 1)'(NREQ);
  localparam logic [CW-1:0] MAX_W  = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] cont_q, cont_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      din_q, din_d;

  logic            rr_found;
  logic [IW-1:0]   rr_idx;
  logic            g_valid, g_last, g_cont;
  logic [7:0]      g_data;
  logic            accept;
  logic [CW-1:0]   cnt_inc;

  // Round-robin search: the candidate just after the previous owner has
  // highest priority, wrapping modulo NREQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      logic [IW:0]   sum;
      logic [IW-1:0] cand;
      sum = {1'b0, last_q} + (IW + 1)'(off);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      cand = sum[IW-1:0];
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Granted-lane view, selected through the one-hot grant mask.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      g_data = g_data | (req_data[8*i +: 8] & {8{grant_q[i]}});
    end
  end

  assign g_valid   = |(req_valid & grant_q);
  assign g_last    = |(req_last & grant_q);
  assign g_cont    = |(cont_q & grant_q);
  assign req_ready = (state_q == DATA && !fifo_prog_full) ? grant_q : '0;
  assign accept    = (state_q == DATA) && !fifo_prog_full && g_valid;
  assign cnt_inc   = cnt_q + 1'b1;

  // NOTE: every variable written here gets its default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    din_d   = din_q;
    unique case (state_q)
      IDLE: begin
        if (rr_found && !fifo_prog_full) begin
          gidx_d  = rr_idx;
          grant_d = NREQ'(1) << rr_idx;
          cnt_d   = '0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (!fifo_prog_full) begin
          wr_en_d = 1'b1;
          din_d   = {1'b1, g_cont, 2'b00, 4'(gidx_q)};
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          wr_en_d = 1'b1;
          din_d   = g_data;
          cnt_d   = cnt_inc;
          // End of message beats truncation when both land on one byte.
          if (g_last || cnt_inc == MAX_W) begin
            cont_d  = g_last ? (cont_q & ~grant_q) : (cont_q | grant_q);
            last_d  = gidx_q;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(NREQ - 1);
      grant_q <= '0;
      cont_q  <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      din_q   <= din_d;
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Scoreboard bench for ftdi_tx_arbiter: source queues feed the lanes, a model
// of packet framing fills the expected FIFO byte queue.
module tb_ftdi_tx_arbiter;

  localparam int NREQ = 3;
  localparam int MB   = 4;

  typedef logic [8:0] item_t;

  logic              clk;
  logic              res_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_prog_full;
  logic              fifo_wr_en;
  logic [7:0]        fifo_din;
  logic [NREQ-1:0]   grant;
  logic              busy;

  ftdi_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .res_n          (res_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .fifo_prog_full (fifo_prog_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din),
    .grant          (grant),
    .busy           (busy)
  );

  int         checks;
  int         passed;
  int         cyc;
  item_t      src_q [NREQ][$];
  logic [7:0] sb [$];
  int         wr_cycles [$];
  bit         src_en [NREQ];
  bit         mdl_cont [NREQ];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Source driver: retire the head item on an accepted handshake, then
  // present the next head well away from the edge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (res_n && req_valid[i] && req_ready[i] && src_q[i].size() > 0)
          void'(src_q[i].pop_front());
      end
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (src_en[i] && src_q[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = src_q[i][0][7:0];
          req_last[i]         = src_q[i][0][8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  // FIFO-side monitor: every write must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (res_n && fifo_wr_en) begin
        wr_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          $error("FAIL extra_write: observed 0x%0h expected no write", fifo_din);
        end else begin
          check("fifo_din", {24'h0, fifo_din}, {24'h0, sb.pop_front()});
        end
      end
    end
  end

  task automatic load(input int id, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = base + 8'(k);
      src_q[id].push_back({(k == n - 1), b});
    end
  endtask

  // Packet model: chunks of at most MB bytes, each behind a header whose
  // bit 6 records whether the previous chunk of this source was cut short.
  task automatic expect_msg(input int id, input int n, input logic [7:0] base);
    int k;
    k = 0;
    while (k < n) begin
      int len;
      len = (n - k > MB) ? MB : (n - k);
      sb.push_back({1'b1, mdl_cont[id], 2'b00, 4'(id)});
      for (int j = 0; j < len; j++) begin
        logic [7:0] b;
        b = base + 8'(k + j);
        sb.push_back(b);
      end
      k += len;
      mdl_cont[id] = (k < n);
    end
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() > 0 || src_q[0].size() > 0 || src_q[1].size() > 0 ||
            src_q[2].size() > 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drained"}, (t < 300), 1);
    check({tag, "_grant_idle"}, grant, 0);
  endtask

  task automatic wait_src(input int id, input int sz, input string tag);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (src_q[id].size() != sz && t < 100);
    check({tag, "_reached"}, (src_q[id].size() == sz), 1);
  endtask

  initial begin
    int wr;
    checks = 0;
    passed = 0;
    res_n = 1'b0;
    fifo_prog_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      src_en[i]   = 1'b1;
      mdl_cont[i] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 8'h00);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    res_n = 1'b1;

    // Single message: header plus three bytes on four consecutive cycles.
    wr_cycles.delete();
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b0, 8'h22});
    src_q[0].push_back({1'b1, 8'h33});
    sb.push_back(8'h80);
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    wait_drain("single");
    check("single_writes", wr_cycles.size(), 4);
    if (wr_cycles.size() == 4)
      check("single_back_to_back", wr_cycles[3] - wr_cycles[0], 3);

    // Round-robin: previous owner was 0, so 1 goes first.
    load(0, 1, 8'hA0);
    load(0, 1, 8'hA3);
    load(1, 1, 8'hA1);
    load(1, 1, 8'hA4);
    load(2, 1, 8'hA2);
    expect_msg(1, 1, 8'hA1);
    expect_msg(2, 1, 8'hA2);
    expect_msg(0, 1, 8'hA0);
    expect_msg(1, 1, 8'hA4);
    expect_msg(0, 1, 8'hA3);
    wait_drain("round_robin");

    // Truncation: six bytes split 4 + 2, second header flags continuation.
    load(1, 6, 8'h40);
    expect_msg(1, 6, 8'h40);
    wait_drain("truncate");
    load(1, 1, 8'h50);
    expect_msg(1, 1, 8'h50);
    wait_drain("cont_cleared");

    // Backpressure for five cycles in the middle of a packet.
    load(0, 4, 8'h60);
    expect_msg(0, 4, 8'h60);
    wait_src(0, 2, "bp_mid");
    fifo_prog_full = 1'b1;
    wr = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_ready_low", req_ready, 0);
      check("bp_grant_held", grant, 3'b001);
      wr += int'(fifo_wr_en);
    end
    check("bp_inflight_writes", wr, 1);
    @(posedge clk);
    #1;
    fifo_prog_full = 1'b0;
    wait_drain("backpressure");

    // Source stall: requester 2 goes quiet, grant must stay put.
    load(2, 3, 8'h70);
    expect_msg(2, 3, 8'h70);
    wait_src(2, 2, "stall_mid");
    src_en[2] = 1'b0;
    load(0, 1, 8'h90);
    load(1, 1, 8'h91);
    expect_msg(0, 1, 8'h90);
    expect_msg(1, 1, 8'h91);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_grant", grant, 3'b100);
      check("stall_ready", req_ready, 3'b100);
    end
    @(posedge clk);
    #1;
    src_en[2] = 1'b1;
    wait_drain("stall");

    // Reset in the middle of a packet from requester 1.
    load(1, 4, 8'hB0);
    sb.push_back(8'h81);
    sb.push_back(8'hB0);
    wait_src(1, 2, "rst_mid");
    res_n = 1'b0;
    #1;
    check("mid_rst_wr_en", fifo_wr_en, 0);
    check("mid_rst_din", fifo_din, 8'h00);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_sb_left", sb.size(), 0);
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      mdl_cont[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    res_n = 1'b1;
    load(1, 1, 8'hC5);
    load(0, 1, 8'hC0);
    expect_msg(0, 1, 8'hC0);
    expect_msg(1, 1, 8'hC5);
    wait_drain("after_reset");

    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
